// File: rtl/dmx_1to4_buf_pkg.sv
// Shared constants for the 1-to-4 buffered demux: lane count, selector width and lane encodings.
package dmx_1to4_buf_pkg;

    localparam int NB_SEL_DEF = 2;
    localparam int NUM_LANES  = 2 ** NB_SEL_DEF;

    typedef enum logic [NB_SEL_DEF-1:0] {
        LANE_A = 2'b00,
        LANE_B = 2'b01,
        LANE_C = 2'b10,
        LANE_D = 2'b11
    } lane_e;

    function automatic logic [NUM_LANES-1:0] sel_onehot(input logic [NB_SEL_DEF-1:0] sel);
        logic [NUM_LANES-1:0] oh;
        oh = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/dmx_1to4_buf_lane_fifo2.sv
// Two-entry FIFO lane, valid/ready on both sides; 1-cycle latency, no pass-through.
// push_rdy drops when full even if a pop happens the same cycle; head holds its last value when empty.
module lane_fifo2 #(
    parameter int NB_DATA = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_vld,
    output logic               push_rdy,
    input  logic [NB_DATA-1:0] push_dat,
    output logic               pop_vld,
    input  logic               pop_rdy,
    output logic [NB_DATA-1:0] pop_dat,
    output logic               full
);

    logic [NB_DATA-1:0] mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         count;
    logic               push_ok;
    logic               pop_ok;

    assign full     = (count == 2'd2);
    assign pop_vld  = (count != 2'd0);
    assign push_rdy = ~full;
    assign push_ok  = push_vld & push_rdy;
    assign pop_ok   = pop_vld & pop_rdy;

    // When empty, the slot behind rd_ptr still holds the word that was popped last.
    assign pop_dat = pop_vld ? mem[rd_ptr] : mem[~rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmx_1to4_buf.sv
// Routes one input word to one of four 2-entry lane FIFOs chosen by i_sel; 1-cycle latency.
// o_ready reflects only the selected lane's full flag; each lane drains independently on i_ready.
module dmx_1to4_buf
    import dmx_1to4_buf_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_SEL  = NB_SEL_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [NB_DATA-1:0]   i_data,
    input  logic [NB_SEL-1:0]    i_sel,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [NB_DATA-1:0]   o_data_a,
    output logic [NB_DATA-1:0]   o_data_b,
    output logic [NB_DATA-1:0]   o_data_c,
    output logic [NB_DATA-1:0]   o_data_d,
    output logic [NUM_LANES-1:0] o_valid,
    input  logic [NUM_LANES-1:0] i_ready,
    output logic [NUM_LANES-1:0] o_full
);

    logic [NUM_LANES-1:0] sel_oh;
    logic [NUM_LANES-1:0] push_vld;
    logic [NUM_LANES-1:0] push_rdy;
    logic [NB_DATA-1:0]   lane_dat [NUM_LANES];

    assign sel_oh   = sel_onehot(i_sel);
    assign push_vld = sel_oh & {NUM_LANES{i_valid}};
    assign o_ready  = push_rdy[i_sel];

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        lane_fifo2 #(
            .NB_DATA (NB_DATA)
        ) u_lane (
            .clk      (i_clk),
            .rst_n    (i_rst_n),
            .push_vld (push_vld[k]),
            .push_rdy (push_rdy[k]),
            .push_dat (i_data),
            .pop_vld  (o_valid[k]),
            .pop_rdy  (i_ready[k]),
            .pop_dat  (lane_dat[k]),
            .full     (o_full[k])
        );
    end

    assign o_data_a = lane_dat[LANE_A];
    assign o_data_b = lane_dat[LANE_B];
    assign o_data_c = lane_dat[LANE_C];
    assign o_data_d = lane_dat[LANE_D];

endmodule

// File: tb/tb_dmx_1to4_buf.sv
// Self-checking bench: per-lane queue model compared every negedge, plus directed literal checks.
module tb_dmx_1to4_buf;

    localparam int NB_DATA = 32;

    logic               i_clk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic [NB_DATA-1:0] i_data = '0;
    logic [1:0]         i_sel = '0;
    logic               i_valid = 1'b0;
    logic               o_ready;
    logic [NB_DATA-1:0] o_data_a, o_data_b, o_data_c, o_data_d;
    logic [3:0]         o_valid;
    logic [3:0]         i_ready = '0;
    logic [3:0]         o_full;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [NB_DATA-1:0] mq [4][$];
    logic [NB_DATA-1:0] last_head [4];

    dmx_1to4_buf #(.NB_DATA(NB_DATA), .NB_SEL(2)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_data   (i_data),
        .i_sel    (i_sel),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .o_data_a (o_data_a),
        .o_data_b (o_data_b),
        .o_data_c (o_data_c),
        .o_data_d (o_data_d),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_full   (o_full)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [NB_DATA-1:0] act, input logic [NB_DATA-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue per lane, capacity 2, pop-before-push but push gated on the pre-edge size.
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < 4; k++) begin
                mq[k].delete();
                last_head[k] = '0;
            end
        end else begin
            bit acc;
            acc = i_valid && (mq[i_sel].size() < 2);
            for (int k = 0; k < 4; k++) begin
                if (i_ready[k] && mq[k].size() > 0) begin
                    last_head[k] = mq[k].pop_front();
                end
            end
            if (acc) mq[i_sel].push_back(i_data);
        end
    end

    function automatic logic [NB_DATA-1:0] exp_head(input int k);
        return (mq[k].size() > 0) ? mq[k][0] : last_head[k];
    endfunction

    always @(negedge i_clk) begin
        if (chk_en) begin
            logic [3:0] ev, ef;
            for (int k = 0; k < 4; k++) begin
                ev[k] = (mq[k].size() > 0);
                ef[k] = (mq[k].size() == 2);
            end
            check("cyc_valid", {28'd0, o_valid}, {28'd0, ev});
            check("cyc_full",  {28'd0, o_full},  {28'd0, ef});
            check("cyc_ready", {31'd0, o_ready}, {31'd0, (mq[i_sel].size() < 2)});
            check("cyc_data_a", o_data_a, exp_head(0));
            check("cyc_data_b", o_data_b, exp_head(1));
            check("cyc_data_c", o_data_c, exp_head(2));
            check("cyc_data_d", o_data_d, exp_head(3));
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [1:0] sel, input logic [NB_DATA-1:0] dat);
        i_valid = 1'b1;
        i_sel   = sel;
        i_data  = dat;
        step();
        i_valid = 1'b0;
    endtask

    initial begin
        // Reset values while still in reset
        #2;
        check("rst_valid", {28'd0, o_valid}, 32'h0);
        check("rst_full",  {28'd0, o_full},  32'h0);
        check("rst_ready", {31'd0, o_ready}, 32'h1);
        check("rst_data_a", o_data_a, 32'h0);
        check("rst_data_d", o_data_d, 32'h0);
        #10;
        i_rst_n = 1'b1;
        chk_en  = 1'b1;
        step();

        // Single word to lane c
        push(2'b10, 32'hDEADBEEF);
        check("c_valid", {28'd0, o_valid}, 32'h4);
        check("c_data", o_data_c, 32'hDEADBEEF);
        check("c_other_a", o_data_a, 32'h0);
        check("c_other_b", o_data_b, 32'h0);

        // Lane b fills, third word refused, drain order 1,2 then hold
        push(2'b01, 32'h1);
        push(2'b01, 32'h2);
        i_valid = 1'b1; i_sel = 2'b01; i_data = 32'h3;
        #1;
        check("b_full", {31'd0, o_full[1]}, 32'h1);
        check("b_ready", {31'd0, o_ready}, 32'h0);
        step();
        i_valid = 1'b0;
        i_ready = 4'b0010;
        check("b_pop1", o_data_b, 32'h1);
        step();
        check("b_pop2", o_data_b, 32'h2);
        step();
        i_ready = 4'b0000;
        check("b_empty", {31'd0, o_valid[1]}, 32'h0);
        check("b_hold", o_data_b, 32'h2);

        // Lane a full with pop pending: no pass-through push
        push(2'b00, 32'h10);
        push(2'b00, 32'h11);
        i_valid = 1'b1; i_sel = 2'b00; i_data = 32'h5; i_ready = 4'b0001;
        #1;
        check("a_ready_full", {31'd0, o_ready}, 32'h0);
        step();
        check("a_full_after_pop", {31'd0, o_full[0]}, 32'h0);
        check("a_ready_after_pop", {31'd0, o_ready}, 32'h1);
        check("a_head_11", o_data_a, 32'h11);
        step();
        i_valid = 1'b0; i_ready = 4'b0000;
        check("a_head_5", o_data_a, 32'h5);
        check("a_not_full", {31'd0, o_full[0]}, 32'h0);

        // Lane d push+pop at count 1
        push(2'b11, 32'hA);
        i_valid = 1'b1; i_sel = 2'b11; i_data = 32'hB; i_ready = 4'b1000;
        step();
        i_valid = 1'b0; i_ready = 4'b0000;
        check("d_valid", {31'd0, o_valid[3]}, 32'h1);
        check("d_not_full", {31'd0, o_full[3]}, 32'h0);
        check("d_head", o_data_d, 32'hB);

        // Fill every lane, then asynchronous reset between edges
        i_ready = 4'b1111;
        repeat (3) step();
        i_ready = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            push(k[1:0], 32'h100 + k);
            push(k[1:0], 32'h200 + k);
        end
        check("all_full", {28'd0, o_full}, 32'hF);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_valid", {28'd0, o_valid}, 32'h0);
        check("arst_full",  {28'd0, o_full},  32'h0);
        check("arst_data_c", o_data_c, 32'h0);
        #1;
        i_rst_n = 1'b1;
        i_ready = 4'b1111;
        repeat (3) step();
        check("post_rst_valid", {28'd0, o_valid}, 32'h0);

        // Random traffic
        for (int n = 0; n < 10000; n++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_sel   = 2'($urandom_range(0, 3));
            i_data  = $urandom;
            i_ready = 4'($urandom_range(0, 15));
            step();
        end
        i_valid = 1'b0;
        i_ready = 4'b1111;
        repeat (4) step();
        check("drained", {28'd0, o_valid}, 32'h0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmx_1to4_buf.md
DMX_1TO4_BUF -- requirements
Module: dmx_1to4_buf

Interface
REQ-001 Parameter NB_DATA, default 32, data width of every lane.
REQ-002 Parameter NB_SEL, default 2, selector width; lane count is 4 = 2**NB_SEL.
REQ-003 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-004 i_clk  input  1  sole clock, all state updates on rising edge.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_data  input  NB_DATA  word to route.
REQ-007 i_sel  input  NB_SEL  destination lane: 00 -> a, 01 -> b, 10 -> c, 11 -> d.
REQ-008 i_valid  input  1  i_data/i_sel valid this cycle.
REQ-009 o_ready  output  1  selected lane can accept; transfer when i_valid & o_ready.
REQ-010 o_data_a/o_data_b/o_data_c/o_data_d  output  NB_DATA each  head word of each lane.
REQ-011 o_valid  output  4  per-lane head valid; bit0=a, bit1=b, bit2=c, bit3=d.
REQ-012 i_ready  input  4  per-lane consumer ready; pop when o_valid[k] & i_ready[k].
REQ-013 o_full  output  4  per-lane buffer holds 2 words.

Function
REQ-014 Each lane SHALL own an independent 2-entry FIFO with a count of 0..2.
REQ-015 o_ready SHALL equal ~o_full[i_sel], combinationally from i_sel, independent of i_valid and i_ready.
REQ-016 Pushes into a full lane SHALL NOT occur, even if the same lane pops in the same cycle (no pass-through).
REQ-017 An accepted word SHALL enter only lane i_sel; the other three lanes stay unchanged.
REQ-018 Latency SHALL be 1 cycle: a word accepted at edge N is shown on o_data_x with o_valid set after edge N; there is no combinational bypass.
REQ-019 Per-lane order SHALL be preserved; there is no ordering guarantee across lanes.
REQ-020 o_valid[k] SHALL be 1 exactly when count[k] > 0; o_full[k] SHALL be 1 exactly when count[k] == 2.
REQ-021 A simultaneous push and pop on a lane with count 1 SHALL leave count 1: the second word becomes head on the next cycle.
REQ-022 A pop with no push SHALL decrement the count; an empty lane SHALL ignore i_ready.
REQ-023 Pops on different lanes and a push to any lane SHALL all complete in the same cycle.
REQ-024 When o_valid[k]=0, o_data_x SHALL hold its last head value (zero after reset).
REQ-025 Read and write pointers SHALL be 1 bit each and wrap 1 -> 0.

Reset
REQ-026 Assertion of i_rst_n=0 SHALL clear all counts and pointers immediately, regardless of clock.
REQ-027 Reset values: o_valid=4'b0000, o_full=4'b0000, o_data_a..d all zero, o_ready=1.
REQ-028 Reset mid-transfer SHALL discard every buffered word; no word is emitted after release.
REQ-029 State SHALL first update on the first rising edge after i_rst_n deasserts.

Structure
REQ-030 Lane count, NB_SEL default and the lane encodings 00..11 SHALL be defined once in the shared project constants package/include.
REQ-031 One sub-module, lane_fifo2 (2-entry FIFO, valid/ready both sides), SHALL be instantiated 4 times; the top holds only select decode and ready mux.

Verification
REQ-032 Reset, then push 0xDEADBEEF to sel=10 with i_ready=0 -> next cycle o_valid=0100 and o_data_c=0xDEADBEEF; other lanes remain 0.
REQ-033 Push 0x1 then 0x2 to lane b with i_ready=0, then present 0x3 -> o_full[1]=1 and o_ready=0; 0x3 is not accepted; the pop order is 0x1, 0x2.
REQ-034 Lane a full and i_ready[0]=1, with 0x5 presented to lane a -> o_ready=0; after the pop, o_full[0]=0 and 0x5 is accepted next cycle.
REQ-035 Lane d count=1 with head 0xA, push 0xB and pop in the same cycle -> the count stays 1 and the next head is 0xB.
REQ-036 Fill all lanes to count 2, then pulse i_rst_n low between edges -> o_valid=0000 and o_full=0000 immediately; after release, none of the stale data appears.
REQ-037 Random traffic over 10k cycles against a per-lane queue model -> no loss, no duplication, order preserved on every lane.
